arm_position_scan_ctrl: RTL and testbench

//  Sequencer for the arm-position ROM: on a one-shot start, reads every ROM word

---
 rtl/arm_scan_pkg.sv | 18 +
 rtl/scan_extreme_tracker.sv | 59 +++++
 rtl/arm_position_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_arm_position_scan_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/arm_scan_pkg.sv
// Shared types and default sizes for the arm-position ROM scan sequencer.
package arm_scan_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 16;
  localparam int DEFAULT_ADDRESS_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_e;

  typedef enum logic {
    TRACK_MAX = 1'b0,
    TRACK_MIN = 1'b1
  } track_mode_e;

endpackage

// File: rtl/scan_extreme_tracker.sv
// Running extreme (max or min) of a word stream; result is published only on commit,
// folding in the word presented on the commit cycle itself.
module scan_extreme_tracker
  import arm_scan_pkg::*;
#(
  parameter int          DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int          ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter track_mode_e MODE          = TRACK_MAX
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_first,
  input  logic                     valid,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic                     commit,
  output logic [DATA_WIDTH-1:0]    value,
  output logic [ADDRESS_WIDTH-1:0] value_address
);

  logic [DATA_WIDTH-1:0]    run_value;
  logic [ADDRESS_WIDTH-1:0] run_address;
  logic                     take;

  // Strict compare keeps the earlier (lower) address on ties.
  always_comb begin
    take = 1'b0;
    if (valid) begin
      if (load_first) begin
        take = 1'b1;
      end else if (MODE == TRACK_MAX) begin
        take = (data > run_value);
      end else begin
        take = (data < run_value);
      end
    end else begin
      take = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_value     <= {DATA_WIDTH{1'b0}};
      run_address   <= {ADDRESS_WIDTH{1'b0}};
      value         <= {DATA_WIDTH{1'b0}};
      value_address <= {ADDRESS_WIDTH{1'b0}};
    end else begin
      if (take) begin
        run_value   <= data;
        run_address <= addr;
      end
      if (commit) begin
        value         <= take ? data : run_value;
        value_address <= take ? addr : run_address;
      end
    end
  end

endmodule

// File: rtl/arm_position_scan_ctrl.sv
// Start/busy/done sequencer that reads every position-ROM word once and reports the largest.
// Defining ARM_SCAN_MIN_TRACK_EN adds smaller_num/smaller_num_address minimum tracking.
module arm_position_scan_ctrl
  import arm_scan_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DEPTH         = 2 ** ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     rom_rd,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    greater_num,
  output logic [ADDRESS_WIDTH-1:0] greater_num_address
`ifdef ARM_SCAN_MIN_TRACK_EN
  ,
  output logic [DATA_WIDTH-1:0]    smaller_num,
  output logic [ADDRESS_WIDTH-1:0] smaller_num_address
`endif
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SCAN  = SCAN;
  localparam logic [1:0] S_DRAIN = DRAIN;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);

  logic [1:0]               state;
  logic                     rd_valid_q;
  logic [ADDRESS_WIDTH-1:0] rd_addr_q;
  logic                     load_first;
  logic                     commit;

  assign load_first = rd_valid_q && (rd_addr_q == {ADDRESS_WIDTH{1'b0}});
  assign commit     = (state == S_DRAIN) && rd_valid_q;

  // done gates start so a request landing on the done cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rom_rd     <= 1'b0;
      rom_addr   <= {ADDRESS_WIDTH{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr_q  <= {ADDRESS_WIDTH{1'b0}};
    end else begin
      rd_valid_q <= rom_rd;
      rd_addr_q  <= rom_addr;
      done       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !done) begin
            state    <= S_SCAN;
            rom_addr <= {ADDRESS_WIDTH{1'b0}};
            rom_rd   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_SCAN: begin
          if (rom_addr == LAST_ADDR) begin
            rom_rd <= 1'b0;
            state  <= S_DRAIN;
          end else begin
            rom_addr <= rom_addr + ADDR_ONE;
          end
        end
        S_DRAIN: begin
          if (rd_valid_q) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          rom_rd <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  scan_extreme_tracker #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .MODE         (TRACK_MAX)
  ) u_max (
    .clk          (clk),
    .rst          (rst),
    .load_first   (load_first),
    .valid        (rd_valid_q),
    .data         (rom_data),
    .addr         (rd_addr_q),
    .commit       (commit),
    .value        (greater_num),
    .value_address(greater_num_address)
  );

`ifdef ARM_SCAN_MIN_TRACK_EN
  scan_extreme_tracker #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .MODE         (TRACK_MIN)
  ) u_min (
    .clk          (clk),
    .rst          (rst),
    .load_first   (load_first),
    .valid        (rd_valid_q),
    .data         (rom_data),
    .addr         (rd_addr_q),
    .commit       (commit),
    .value        (smaller_num),
    .value_address(smaller_num_address)
  );
`endif

endmodule

// File: tb/tb_arm_position_scan_ctrl.sv
// Scoreboard bench: expected extremes are queued at each start and compared on every done pulse.
module tb_arm_position_scan_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  typedef struct {
    logic [DW-1:0] mx;
    logic [AW-1:0] mxa;
    logic [DW-1:0] mn;
    logic [AW-1:0] mna;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          rom_rd;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = 16'h0000;
  logic          busy;
  logic          done;
  logic [DW-1:0] greater_num;
  logic [AW-1:0] greater_num_address;
`ifdef ARM_SCAN_MIN_TRACK_EN
  logic [DW-1:0] smaller_num;
  logic [AW-1:0] smaller_num_address;
`endif

  logic [DW-1:0] mem [DEPTH];
  exp_t          sb [$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            done_cnt = 0;
  logic [DW-1:0] held_max = 16'h0000;

  arm_position_scan_ctrl #(
    .DATA_WIDTH   (DW),
    .ADDRESS_WIDTH(AW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .rom_rd             (rom_rd),
    .rom_addr           (rom_addr),
    .rom_data           (rom_data),
    .busy               (busy),
    .done               (done),
    .greater_num        (greater_num),
    .greater_num_address(greater_num_address)
`ifdef ARM_SCAN_MIN_TRACK_EN
    ,
    .smaller_num        (smaller_num),
    .smaller_num_address(smaller_num_address)
`endif
  );

  always #5 clk = ~clk;

  // One-cycle registered ROM read.
  always @(posedge clk) begin
    if (rom_rd) rom_data <= mem[rom_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model();
    exp_t e;
    e.mx = mem[0]; e.mxa = 3'd0; e.mn = mem[0]; e.mna = 3'd0;
    for (int i = 1; i < DEPTH; i++) begin
      if (mem[i] > e.mx) begin e.mx = mem[i]; e.mxa = AW'(i); end
      if (mem[i] < e.mn) begin e.mn = mem[i]; e.mna = AW'(i); end
    end
    return e;
  endfunction

  // Done monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("greater_num", 32'(greater_num), 32'(e.mx));
        check_eq("greater_num_address", 32'(greater_num_address), 32'(e.mxa));
`ifdef ARM_SCAN_MIN_TRACK_EN
        check_eq("smaller_num", 32'(smaller_num), 32'(e.mn));
        check_eq("smaller_num_address", 32'(smaller_num_address), 32'(e.mna));
`else
        check_eq("busy_low_on_done", 32'(busy), 32'd0);
`endif
      end
    end
  end

  // start_mask bit c drives start during cycle c; cycle 0 launches the scan.
  task automatic run_scan(input logic [15:0] start_mask);
    exp_t e;
    int   d0;
    int   k;
    e  = model();
    sb.push_back(e);
    d0 = done_cnt;
    for (int c = 0; c <= 11; c++) begin
      start = start_mask[c];
      @(posedge clk);
      #1;
      start = 1'b0;
      k = c + 1;
      if (k <= DEPTH) begin
        check_eq("rom_rd_scan", 32'(rom_rd), 32'd1);
        check_eq("rom_addr_seq", 32'(rom_addr), 32'(k - 1));
      end else begin
        check_eq("rom_rd_idle", 32'(rom_rd), 32'd0);
      end
      check_eq("busy", 32'(busy), (k <= DEPTH + 1) ? 32'd1 : 32'd0);
      check_eq("done", 32'(done), (k == DEPTH + 2) ? 32'd1 : 32'd0);
      if (k == 5) check_eq("held_result", 32'(greater_num), 32'(held_max));
    end
    check_eq("done_count", 32'(done_cnt - d0), 32'd1);
    held_max = e.mx;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_rom_rd", 32'(rom_rd), 32'd0);
    check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_eq("rst_greater_num", 32'(greater_num), 32'd0);
    check_eq("rst_greater_addr", 32'(greater_num_address), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ties keep the lower address; min is 0 at address 5.
    mem = '{16'd5, 16'd9, 16'd3, 16'd9, 16'd1, 16'd0, 16'd2, 16'd7};
    run_scan(16'h0001);

    mem = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_scan(16'h0001);

    mem = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'hFFFF};
    run_scan(16'h0001);

    // Starts while busy and on the done cycle are ignored.
    mem = '{16'd5, 16'd9, 16'd3, 16'd9, 16'd1, 16'd0, 16'd2, 16'd7};
    run_scan(16'h0411);
    repeat (3) @(posedge clk);
    #1;
    check_eq("no_restart_busy", 32'(busy), 32'd0);
    check_eq("no_restart_rd", 32'(rom_rd), 32'd0);

    // Mid-scan abort.
    mem = '{16'd4, 16'd6, 16'd1, 16'd8, 16'd2, 16'd3, 16'd5, 16'd7};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_rom_rd", 32'(rom_rd), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_greater_num", 32'(greater_num), 32'd0);
    check_eq("abort_greater_addr", 32'(greater_num_address), 32'd0);
    held_max = 16'h0000;
    begin
      int d0;
      d0 = done_cnt;
      repeat (12) @(posedge clk);
      #1;
      check_eq("abort_no_done", 32'(done_cnt - d0), 32'd0);
    end
    run_scan(16'h0001);

    repeat (2) @(posedge clk);
    check_eq("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
